iccm_boot_loader: RTL



---
 rtl/iccm_boot_pkg.sv | 27 ++
 rtl/iccm_boot_uart_rx.sv | 110 +++++++++++
 rtl/iccm_boot_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/iccm_boot_pkg.sv
// Shared types and constants for the ICCM serial boot loader.
// ICCM_BOOT_CHECKSUM_EN adds the LD_CHK loader state.
package iccm_boot_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
`ifdef ICCM_BOOT_CHECKSUM_EN
        LD_CHK,
`endif
        LD_DONE
    } load_state_e;

    localparam int ErrFrame    = 0;
    localparam int ErrOverflow = 1;
    localparam int ErrChecksum = 2;

    localparam int MinClksPerBit = 4;

endpackage

// File: rtl/iccm_boot_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchroniser and a runtime baud divisor.
// Emits a one-cycle byte-valid pulse on a good stop bit, a frame-error pulse otherwise.
module iccm_boot_uart_rx
    import iccm_boot_pkg::*;
#(
    parameter int ClkDivWidth = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [ClkDivWidth-1:0] clks_per_bit,
    input  logic                   rx,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    output logic                   frame_err
);

    logic [ClkDivWidth-1:0] div;
    logic [ClkDivWidth-1:0] half;
    logic [ClkDivWidth-1:0] cnt;
    logic                   sync1;
    logic                   sync2;
    logic                   prev;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    rx_state_e              state;

    assign div  = (clks_per_bit < ClkDivWidth'(MinClksPerBit)) ?
                  ClkDivWidth'(MinClksPerBit) : clks_per_bit;
    assign half = div >> 1;

    assign rx_data = shift;

    // NOTE: every register here is written with <= so all flops update from
    // the same pre-edge values; a blocking '=' would let sync2 see this cycle's sync1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            prev      <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= rx;
            sync2     <= sync1;
            prev      <= sync2;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (!en) begin
                state <= RX_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    RX_IDLE: begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (prev && !sync2) begin
                            state <= RX_START;
                        end
                    end

                    RX_START: begin
                        if (cnt == half - 1'b1) begin
                            cnt   <= '0;
                            // A line that is high again at mid-start was a glitch.
                            state <= sync2 ? RX_IDLE : RX_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    RX_DATA: begin
                        if (cnt == div - 1'b1) begin
                            cnt     <= '0;
                            shift   <= {sync2, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= RX_STOP;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    RX_STOP: begin
                        if (cnt == div - 1'b1) begin
                            cnt   <= '0;
                            state <= RX_IDLE;
                            if (sync2) begin
                                rx_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/iccm_boot_loader.sv
// Serial boot loader: assembles UART bytes into words and writes them to the ICCM
// while holding the core in reset. ICCM_BOOT_CHECKSUM_EN enables the trailing XOR checksum word.
module iccm_boot_loader
    import iccm_boot_pkg::*;
#(
    parameter int          AddrWidth   = 12,
    parameter int          DataWidth   = 32,
    parameter int          ClkDivWidth = 16,
    parameter logic [31:0] EndMarker   = 32'h0000_0FFF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ClkDivWidth-1:0] clks_per_bit_i,
    input  logic                   boot_en_i,
    input  logic                   rx_i,
    output logic                   we_o,
    output logic [AddrWidth-1:0]   addr_o,
    output logic [DataWidth-1:0]   wdata_o,
    output logic                   core_rst_o,
    output logic                   done_o,
    output logic [2:0]             err_o,
    output logic [AddrWidth:0]     word_cnt_o
);

    localparam int                   NumLanes  = DataWidth / 8;
    localparam int                   LaneWidth = (NumLanes > 1) ? $clog2(NumLanes) : 1;
    localparam logic [LaneWidth-1:0] LastLane  = LaneWidth'(NumLanes - 1);
    localparam logic [DataWidth-1:0] Marker    = DataWidth'(EndMarker);

    load_state_e            state;
    logic                   rx_en;
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_frame_err;
    logic                   boot_q;
    logic                   boot_rise;
    logic [AddrWidth-1:0]   addr_q;
    logic [LaneWidth-1:0]   lane_q;
    logic [DataWidth-1:0]   word_q;
    logic [DataWidth-1:0]   next_word;
    logic                   word_last;
    logic                   frame_q;
    logic                   ovf_q;
`ifdef ICCM_BOOT_CHECKSUM_EN
    logic                   chk_q;
    logic [DataWidth-1:0]   csum_q;
`endif

`ifdef ICCM_BOOT_CHECKSUM_EN
    assign rx_en = (state == LD_LOAD) || (state == LD_CHK);
`else
    assign rx_en = (state == LD_LOAD);
`endif

    iccm_boot_uart_rx #(
        .ClkDivWidth (ClkDivWidth)
    ) u_rx (
        .clk          (clk_i),
        .rst          (rst_i),
        .en           (rx_en),
        .clks_per_bit (clks_per_bit_i),
        .rx           (rx_i),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_err    (rx_frame_err)
    );

    assign boot_rise = boot_en_i && !boot_q;
    assign word_last = rx_valid && (lane_q == LastLane);

    // NOTE: next_word gets its full default before the lane overwrite, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_word = word_q;
        next_word[lane_q*8 +: 8] = rx_data;
    end

    always_comb begin
        err_o              = '0;
        err_o[ErrFrame]    = frame_q;
        err_o[ErrOverflow] = ovf_q;
`ifdef ICCM_BOOT_CHECKSUM_EN
        err_o[ErrChecksum] = chk_q;
`else
        err_o[ErrChecksum] = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= LD_IDLE;
            boot_q     <= 1'b0;
            addr_q     <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            frame_q    <= 1'b0;
            ovf_q      <= 1'b0;
            we_o       <= 1'b0;
            addr_o     <= '0;
            wdata_o    <= '0;
            core_rst_o <= 1'b1;
            done_o     <= 1'b0;
            word_cnt_o <= '0;
`ifdef ICCM_BOOT_CHECKSUM_EN
            chk_q      <= 1'b0;
            csum_q     <= '0;
`endif
        end else begin
            boot_q <= boot_en_i;
            we_o   <= 1'b0;

            // Frame errors leave the lane counter alone; the bad byte is simply skipped.
            if (rx_en && rx_frame_err) begin
                frame_q <= 1'b1;
            end
            if (rx_en && rx_valid) begin
                word_q <= next_word;
                lane_q <= (lane_q == LastLane) ? '0 : lane_q + 1'b1;
            end

            case (state)
                LD_IDLE, LD_DONE: begin
                    if (boot_rise) begin
                        state      <= LD_LOAD;
                        addr_q     <= '0;
                        lane_q     <= '0;
                        frame_q    <= 1'b0;
                        ovf_q      <= 1'b0;
                        word_cnt_o <= '0;
                        core_rst_o <= 1'b1;
                        done_o     <= 1'b0;
`ifdef ICCM_BOOT_CHECKSUM_EN
                        chk_q      <= 1'b0;
                        csum_q     <= '0;
`endif
                    end
                end

                LD_LOAD: begin
                    if (word_last) begin
                        if (next_word == Marker) begin
`ifdef ICCM_BOOT_CHECKSUM_EN
                            state      <= LD_CHK;
`else
                            state      <= LD_DONE;
                            done_o     <= 1'b1;
                            core_rst_o <= 1'b0;
`endif
                        end else if (word_cnt_o[AddrWidth]) begin
                            // Every ICCM word already holds image data.
                            ovf_q      <= 1'b1;
                            state      <= LD_DONE;
                            done_o     <= 1'b1;
                            core_rst_o <= 1'b0;
                        end else begin
                            we_o       <= 1'b1;
                            addr_o     <= addr_q;
                            wdata_o    <= next_word;
                            addr_q     <= addr_q + 1'b1;
                            word_cnt_o <= word_cnt_o + 1'b1;
`ifdef ICCM_BOOT_CHECKSUM_EN
                            csum_q     <= csum_q ^ next_word;
`endif
                        end
                    end
                end

`ifdef ICCM_BOOT_CHECKSUM_EN
                LD_CHK: begin
                    if (word_last) begin
                        chk_q      <= (next_word != csum_q);
                        state      <= LD_DONE;
                        done_o     <= 1'b1;
                        core_rst_o <= 1'b0;
                    end
                end
`endif

                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule
